// File: rtl/adpll_fsk_demod.sv
// Integrate-and-dump FSK demodulator behind an ADPLL: waits for channel lock to settle,
// hunts for the access address with symbol-edge realignment, then recovers payload bits.
module adpll_fsk_demod #(
   parameter int OSR        = 32,
   parameter int ERRW       = 12,
   parameter int SETTLE_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   channel_lock,
   input  logic signed [ERRW-1:0] freq_err,
   input  logic [31:0]            access_addr,
   input  logic [10:0]            payload_bits,
   output logic                   data_out,
   output logic                   data_valid,
   output logic                   sync_found,
   output logic [1:0]             state
);

   localparam int CW   = $clog2(OSR);
   localparam int ACCW = ERRW + CW;
   localparam int SW   = $clog2(SETTLE_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SYNC   = 2'd2,
      ST_DATA   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [ACCW-1:0] acc_q, acc_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   settle_q, settle_d;
   logic [31:0]     sr_q, sr_d;
   logic [10:0]     len_q, len_d;
   logic [10:0]     bitcnt_q, bitcnt_d;
   logic            prev_neg_q, prev_neg_d;
   logic            data_out_q, data_out_d;
   logic            data_valid_q, data_valid_d;
   logic            sync_found_q, sync_found_d;

   logic            run_s;
   logic [ACCW-1:0] fe_ext_s;
   logic [ACCW-1:0] sum_s;
   logic            dump_s;
   logic            bit_s;
   logic            sign_chg_s;
   logic [31:0]     sr_shift_s;

   assign run_s      = en && channel_lock;
   assign fe_ext_s   = {{CW{freq_err[ERRW-1]}}, freq_err};
   assign sum_s      = acc_q + fe_ext_s;
   assign dump_s     = ((state_q == ST_SYNC) || (state_q == ST_DATA)) && (cnt_q == CW'(OSR - 1));
   // A zero sum is non-negative and therefore decodes as a 1.
   assign bit_s      = ~sum_s[ACCW-1];
   assign sign_chg_s = freq_err[ERRW-1] != prev_neg_q;
   assign sr_shift_s = {bit_s, sr_q[31:1]};

   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      settle_d     = settle_q;
      sr_d         = sr_q;
      len_d        = len_q;
      bitcnt_d     = bitcnt_q;
      prev_neg_d   = freq_err[ERRW-1];
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      sync_found_d = 1'b0;

      if (!run_s) begin
         state_d    = ST_IDLE;
         acc_d      = '0;
         cnt_d      = '0;
         settle_d   = '0;
         sr_d       = '0;
         len_d      = '0;
         bitcnt_d   = '0;
         prev_neg_d = 1'b0;
         data_out_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d  = ST_SETTLE;
               settle_d = '0;
               acc_d    = '0;
               cnt_d    = '0;
            end
            ST_SETTLE: begin
               acc_d = '0;
               cnt_d = '0;
               if (settle_q == SW'(SETTLE_CYC - 1)) begin
                  state_d  = ST_SYNC;
                  settle_d = '0;
                  sr_d     = '0;
               end else begin
                  settle_d = settle_q + SW'(1);
               end
            end
            ST_SYNC: begin
               if (dump_s) begin
                  acc_d = '0;
                  cnt_d = '0;
                  sr_d  = sr_shift_s;
                  if (sr_shift_s == access_addr) begin
                     sync_found_d = 1'b1;
                     state_d      = ST_DATA;
                     len_d        = payload_bits;
                     bitcnt_d     = '0;
                  end else begin
                     state_d = ST_SYNC;
                  end
               end else if (sign_chg_s) begin
                  // Symbol edge seen mid-symbol: restart the integration on this sample.
                  acc_d = fe_ext_s;
                  cnt_d = CW'(1);
               end else begin
                  acc_d = sum_s;
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_DATA: begin
               if (dump_s) begin
                  acc_d = '0;
                  cnt_d = '0;
               end else begin
                  acc_d = sum_s;
                  cnt_d = cnt_q + CW'(1);
               end
               if (len_q == 11'd0) begin
                  state_d = ST_SYNC;
                  sr_d    = '0;
               end else if (dump_s) begin
                  data_out_d   = bit_s;
                  data_valid_d = 1'b1;
                  bitcnt_d     = bitcnt_q + 11'd1;
                  if ((bitcnt_q + 11'd1) == len_q) begin
                     state_d = ST_SYNC;
                     sr_d    = '0;
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  state_d = ST_DATA;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         acc_q        <= '0;
         cnt_q        <= '0;
         settle_q     <= '0;
         sr_q         <= '0;
         len_q        <= '0;
         bitcnt_q     <= '0;
         prev_neg_q   <= 1'b0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
         sync_found_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         settle_q     <= settle_d;
         sr_q         <= sr_d;
         len_q        <= len_d;
         bitcnt_q     <= bitcnt_d;
         prev_neg_q   <= prev_neg_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         sync_found_q <= sync_found_d;
      end
   end

   assign state      = state_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign sync_found = sync_found_q;

endmodule

// File: doc/adpll_fsk_demod.md
ADPLL_FSK_DEMOD -- requirements
Module: adpll_fsk_demod

Interface
REQ-001 SHALL have parameter OSR, default 32: samples per symbol at the 32 MHz clk (1 Mbps); power of two, 4..64.
REQ-002 SHALL have parameter ERRW, default 12: width of the signed freq_err sample.
REQ-003 SHALL have parameter SETTLE_CYC, default 64: clk cycles waited after lock before searching.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: block enable; low forces IDLE.
REQ-007 SHALL have port channel_lock, input, 1: ADPLL channel lock indication.
REQ-008 SHALL have port freq_err, input, ERRW signed: one frequency-error sample per clk; positive means the data_mod=1 deviation.
REQ-009 SHALL have port access_addr, input, 32: sync word, compared LSB-first.
REQ-010 SHALL have port payload_bits, input, 11: payload length in bits, sampled on entry to DATA.
REQ-011 SHALL have port data_out, output, 1: recovered payload bit.
REQ-012 SHALL have port data_valid, output, 1: one-cycle strobe qualifying data_out.
REQ-013 SHALL have port sync_found, output, 1: one-cycle pulse on an access-address match.
REQ-014 SHALL have port state, output, 2: IDLE=0, SETTLE=1, SYNC=2, DATA=3.

Function
REQ-015 SHALL run an FSM with these transitions: IDLE->SETTLE when en&&channel_lock; SETTLE->SYNC after SETTLE_CYC cycles; SYNC->DATA on match; DATA->SYNC after payload_bits symbols.
REQ-016 SHALL return to IDLE on the cycle after en or channel_lock is sampled low, from any state, clearing the accumulator, counters, shift register and strobes; this takes priority over all other events.
REQ-017 SHALL integrate and dump: accumulator width ERRW+log2(OSR), sign-extended, no saturation; sample counter 0..OSR-1.
REQ-018 SHALL dump at counter==OSR-1 as follows: bit = (acc+freq_err >= 0); acc cleared; counter set to 0.
REQ-019 SHALL treat a zero sum as a 1 bit.
REQ-020 SHALL realign timing in SYNC only: when the sign of freq_err differs from the previous sample's sign and no dump occurs this cycle, set acc <= freq_err and counter <= 1.
REQ-021 SHALL ignore sign transitions in DATA, which runs free-running at OSR.
REQ-022 SHALL shift each bit in SYNC as sr <= {bit, sr[31:1]}, and SHALL NOT assert data_valid in SYNC.
REQ-023 SHALL pulse sync_found for one cycle, one cycle after the dump whose bit makes sr==access_addr, and enter DATA that same cycle.
REQ-024 SHALL clear sr on entry to SYNC.
REQ-025 SHALL pulse data_valid for one cycle in DATA, one cycle after each dump, with data_out holding that bit until the next dump.
REQ-026 SHALL return from DATA to SYNC on the same cycle as the final data_valid.
REQ-027 SHALL go DATA->SYNC directly, with no data_valid, when payload_bits==0.
REQ-028 SHALL accumulate only in SYNC and DATA; the counter and acc are held at 0 in IDLE and SETTLE.
REQ-029 SHALL restart the settle count if channel_lock drops during SETTLE.

Reset
REQ-030 SHALL, while rst is high at a clk edge, drive state=IDLE and data_out, data_valid and sync_found to 0, and clear the accumulator, counters and sr.
REQ-031 SHALL begin normal operation on the first clk edge after rst is released.

Verification
REQ-032 SHALL cover reset mid-DATA: assert rst for 2 cycles during payload bit 3 -> next edge state=0, all outputs 0, no further strobes.
REQ-033 SHALL cover settle timing: with en=1, raise channel_lock -> state=1 for exactly 64 cycles, then state=2.
REQ-034 SHALL cover sync with phase offset: preamble 0x55 then access_addr 0x8E89BED6, LSB-first, at +/-200 per sample, OSR=32, symbol edges offset 7 samples -> exactly one sync_found, one cycle after the last AA symbol's final sample; state=3.
REQ-035 SHALL cover payload recovery: payload_bits=16, data 0xA5C3 LSB-first -> 16 data_valid pulses spaced 32 cycles, data_out=1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then state=2.
REQ-036 SHALL cover lock loss: drop channel_lock during payload bit 5 -> state=0 next cycle, no 6th data_valid.
REQ-037 SHALL cover edge data: payload_bits=0 returns to SYNC with no data_valid; an all-zero freq_err symbol yields bit 1.
